vram_frame_reader: RTL and testbench
====================================

# vram_frame_reader

Parametrised frame readout engine that sweeps a rectangular image out of video RAM and presents it as a pixel stream with valid/ready flow control and frame/line markers. It sits between the CPU's display VRAM read port and any pixel consumer (display scan-out, capture/dump logic). Compared with the fixed single-image, fixed-width scan, it is generalised in pixel width, image geometry, image count and read latency. It adds backpressure, 2:1 decimation and abort.

## Interface

Parameters:
- DATA_W, 8: pixel width in bits.
- ADDR_W, 32: VRAM address width.
- IMG_W, 256: image width in pixels; power of two, at least 4.
- IMG_H, 256: image height in lines; at least 2.
- N_IMG, 2: number of images stored back to back; image k base = k*IMG_W*IMG_H.
- RD_LAT, 2: VRAM read latency in cycles, 1..4.

Ports:
- clk, in, 1: single clock; all logic on rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- start, in, 1: level from button logic; a rising edge (low in cycle n-1, high in cycle n) launches a frame.
- image_sel, in, max(1,$clog2(N_IMG)): image index, sampled on the start edge; values ≥ N_IMG clamp to N_IMG-1.
- half_mode, in, 1: sampled on the start edge; 1 = 2:1 decimation.
- abort, in, 1: synchronous frame cancel.
- vram_addr, out, ADDR_W: read address.
- vram_rd_en, out, 1: read strobe.
- vram_rdata, in, DATA_W: read data, valid exactly RD_LAT cycles after the cycle with vram_rd_en=1.
- pix_data, out, DATA_W: pixel.
- pix_valid, out, 1.
- pix_ready, in, 1.
- pix_sof, out, 1: qualifies the first pixel of the frame.
- pix_eol, out, 1: qualifies the last pixel of each line.
- pix_eof, out, 1: qualifies the last pixel of the frame.
- busy, out, 1: high from the start edge until done.
- done, out, 1: one-cycle pulse at frame completion or abort completion.

## Operation

- State machine:
  - IDLE → ISSUE on start edge.
  - ISSUE → DRAIN when the last address has been issued.
  - DRAIN → DONE when the FIFO is empty and no reads are in flight.
  - DONE → IDLE unconditionally (done=1 for that one cycle).
- Start edges outside IDLE are ignored. The edge detector still tracks start, so holding start high does not retrigger.
- Address generation:
  - vram_addr = base + y*IMG_W + x, with base = sel*IMG_W*IMG_H.
  - Normal mode: x steps 0..IMG_W-1, then y steps 0..IMG_H-1.
  - Half mode: x and y step by 2, giving an IMG_W/2 × floor((IMG_H+1)/2) frame.
  - All arithmetic is unsigned, modulo 2^ADDR_W.
- Credit-based flow control:
  - Output FIFO depth is RD_LAT+2.
  - A read may issue only when (in-flight reads + FIFO occupancy) < depth, so returning data is never dropped.
  - With pix_ready held high, reads issue on every cycle.
- Markers travel with each pixel through the FIFO. They are computed from (x, y) at issue time, so they align with the pixel under any backpressure.
- Standard handshake:
  - A pixel transfers when pix_valid && pix_ready.
  - While pix_valid=1 and pix_ready=0, pix_data and all markers stay stable.
  - pix_valid never drops without a transfer, except on abort or reset.
- Abort (ISSUE or DRAIN):
  - Issuing stops in the same cycle.
  - The FIFO is flushed and pix_valid deasserts the next cycle.
  - Data for in-flight reads is discarded when it returns.
  - The FSM goes to DONE once the in-flight count reaches 0.
  - Abort in IDLE or DONE has no effect.

## Timing

- Reset values: vram_addr=0, vram_rd_en=0, pix_data=0, pix_valid=0, all markers 0, busy=0, done=0; FSM in IDLE; counters and FIFO cleared. Reset mid-frame discards everything immediately.
- Cycle numbering: call cycle 0 the cycle in which the start edge is sampled.
  - busy=1 from cycle 1.
  - First vram_rd_en=1 in cycle 1.
  - First pix_valid=1 in cycle RD_LAT+2.
- Throughput with pix_ready held high: 1 pixel/cycle. The frame of P pixels ends with done in cycle P+RD_LAT+2.
- busy falls in the same cycle that done pulses.

## Test plan

- Geometry IMG_W=4, IMG_H=3, N_IMG=2, RD_LAT=2; VRAM model returns data = addr[7:0]; pix_ready held high; start with image_sel=1. Required:
  - 12 pixels 12..23 on consecutive cycles, first in cycle 4.
  - sof on 12; eol on 15, 19, 23; eof on 23.
  - done in cycle 16.
- Same geometry, half_mode=1, image_sel=0. Required:
  - pixels 0, 2, 8, 10.
  - eol on 2 and 10; eof on 10.
- Random pix_ready (50%), full 12-pixel frame. Required:
  - exact sequence 0..11 with no loss or duplicates.
  - data and markers stable while stalled.
  - vram_rd_en never exceeds the credit limit.
- Abort asserted on the 5th transfer. Required:
  - pix_valid=0 the next cycle.
  - done within RD_LAT+1 cycles.
  - a following start produces a clean frame from pixel 0.
- Start held high across the whole frame, plus a second edge mid-frame. Required: exactly one frame and one done pulse.
- reset_n pulsed low mid-frame. Required: all outputs go to zero asynchronously; no pix_valid until the next start edge.

Source files
------------

// File: rtl/vram_frame_reader.sv
// rtl/vram_frame_reader.sv - sweeps one stored image out of VRAM as a flow-controlled pixel stream
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   start, image_sel          rising edge of start launches a frame of image image_sel
//   half_mode                 2:1 decimation in x and y, sampled on the start edge
//   abort                     cancels the running frame
//   vram_addr/rd_en/rdata     VRAM read port, rdata valid RD_LAT cycles after rd_en
//   pix_data/valid/ready      pixel stream handshake
//   pix_sof/eol/eof           frame/line markers qualified by pix_valid
//   busy, done                frame in progress, one-cycle completion pulse
module vram_frame_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 32,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int N_IMG  = 2,
    parameter int RD_LAT = 2
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          start,
    input  logic [((N_IMG > 1) ? $clog2(N_IMG) : 1)-1:0]  image_sel,
    input  logic                                          half_mode,
    input  logic                                          abort,
    output logic [ADDR_W-1:0]                             vram_addr,
    output logic                                          vram_rd_en,
    input  logic [DATA_W-1:0]                             vram_rdata,
    output logic [DATA_W-1:0]                             pix_data,
    output logic                                          pix_valid,
    input  logic                                          pix_ready,
    output logic                                          pix_sof,
    output logic                                          pix_eol,
    output logic                                          pix_eof,
    output logic                                          busy,
    output logic                                          done
);

    localparam int DEPTH = RD_LAT + 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int SW    = (N_IMG > 1) ? $clog2(N_IMG) : 1;
    localparam int EW    = DATA_W + 3;
    localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(IMG_W * IMG_H);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    logic                r_start_d;
    logic                r_half;
    logic                r_aborting;
    logic [ADDR_W-1:0]   r_base;
    logic [XW-1:0]       r_x;
    logic [YW-1:0]       r_y;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_mk;
    logic [RD_LAT-1:0]   r_pv;
    logic [2:0]          r_pm [RD_LAT];
    logic [CW-1:0]       r_used;
    logic [EW-1:0]       r_mem [DEPTH];
    logic [PW-1:0]       r_wp;
    logic [PW-1:0]       r_rp;
    logic [CW-1:0]       r_count;
    logic                r_busy;
    logic                r_done;

    logic                w_start_edge;
    logic                w_pop;
    logic                w_push;
    logic                w_abort;
    logic                w_grant;
    logic                w_issue;
    logic                w_start_issue;
    logic                w_inflight_next;
    logic [CW-1:0]       w_count_next;
    logic [XW-1:0]       w_x_step;
    logic [YW-1:0]       w_y_step;
    logic [XW-1:0]       w_x_last_val;
    logic [YW-1:0]       w_y_last_val;
    logic                w_x_last;
    logic                w_y_last;
    logic                w_sof;
    logic                w_eol;
    logic                w_eof;
    logic [ADDR_W-1:0]   w_addr;
    logic [SW-1:0]       w_sel;
    logic [ADDR_W-1:0]   w_base_new;
    logic [2:0]          w_head_mk;

    assign w_start_edge  = start & ~r_start_d;
    assign w_pop         = (r_count != '0) & pix_ready;
    assign w_abort       = abort & ((r_state == S_ISSUE) | (r_state == S_DRAIN));
    // Returning data is dropped once an abort has been seen.
    assign w_push        = r_pv[RD_LAT-1] & ~r_aborting & ~w_abort;
    assign w_count_next  = r_count - CW'(w_pop) + CW'(w_push);

    // r_used counts every read already scheduled whose pixel has not left the
    // FIFO, so it bounds in-flight reads plus occupancy; a pop this cycle frees
    // its slot immediately, which keeps the stream at one pixel per cycle.
    assign w_grant       = (r_used - CW'(w_pop)) < CW'(DEPTH);
    assign w_issue       = (r_state == S_ISSUE) & ~w_abort & w_grant;
    assign w_start_issue = (r_state == S_IDLE) & w_start_edge;

    // Reads still outstanding after this clock edge.
    always_comb begin
        w_inflight_next = r_rd_en;
        for (int k = 0; k < RD_LAT - 1; k++) begin
            w_inflight_next = w_inflight_next | r_pv[k];
        end
    end

    assign w_x_step     = r_half ? XW'(2) : XW'(1);
    assign w_y_step     = r_half ? YW'(2) : YW'(1);
    assign w_x_last_val = r_half ? XW'(IMG_W - 2) : XW'(IMG_W - 1);
    assign w_y_last_val = r_half ? YW'(((IMG_H - 1) / 2) * 2) : YW'(IMG_H - 1);
    assign w_x_last     = (r_x == w_x_last_val);
    assign w_y_last     = (r_y == w_y_last_val);
    assign w_sof        = (r_x == '0) & (r_y == '0);
    assign w_eol        = w_x_last;
    assign w_eof        = w_x_last & w_y_last;
    assign w_addr       = r_base + (ADDR_W'(r_y) << XW) + ADDR_W'(r_x);

    assign w_sel        = (int'(image_sel) >= N_IMG) ? SW'(N_IMG - 1) : image_sel;
    assign w_base_new   = ADDR_W'(w_sel) * FRAME_PIX;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_start_d  <= 1'b0;
            r_half     <= 1'b0;
            r_aborting <= 1'b0;
            r_base     <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_rd_en    <= 1'b0;
            r_addr     <= '0;
            r_mk       <= '0;
            r_pv       <= '0;
            r_used     <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_pm[k] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_start_d <= start;
            r_done    <= 1'b0;

            // Markers ride alongside each outstanding read.
            r_pv[0] <= r_rd_en;
            r_pm[0] <= r_mk;
            for (int k = 1; k < RD_LAT; k++) begin
                r_pv[k] <= r_pv[k-1];
                r_pm[k] <= r_pm[k-1];
            end

            if (w_push) begin
                r_mem[r_wp] <= {r_pm[RD_LAT-1], vram_rdata};
                r_wp        <= (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + PW'(1);
            end
            if (w_pop) begin
                r_rp <= (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + PW'(1);
            end
            r_count <= w_count_next;
            r_used  <= r_used - CW'(w_pop) + CW'(w_issue | w_start_issue);

            case (r_state)
                S_IDLE: begin
                    r_rd_en <= 1'b0;
                    if (w_start_edge) begin
                        // The first read goes out straight from the start edge.
                        r_state    <= S_ISSUE;
                        r_busy     <= 1'b1;
                        r_aborting <= 1'b0;
                        r_half     <= half_mode;
                        r_base     <= w_base_new;
                        r_rd_en    <= 1'b1;
                        r_addr     <= w_base_new;
                        r_mk       <= 3'b100;
                        r_x        <= half_mode ? XW'(2) : XW'(1);
                        r_y        <= '0;
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        r_rd_en <= 1'b1;
                        r_addr  <= w_addr;
                        r_mk    <= {w_sof, w_eol, w_eof};
                        if (w_x_last) begin
                            r_x <= '0;
                            if (w_y_last) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_y <= r_y + w_y_step;
                            end
                        end else begin
                            r_x <= r_x + w_x_step;
                        end
                    end else begin
                        r_rd_en <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    r_rd_en <= 1'b0;
                    if (!w_abort && (w_count_next == '0) && !w_inflight_next) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_rd_en    <= 1'b0;
                    r_aborting <= 1'b0;
                end
            endcase

            if (w_abort) begin
                r_rd_en    <= 1'b0;
                r_aborting <= 1'b1;
                r_count    <= '0;
                r_wp       <= '0;
                r_rp       <= '0;
                r_used     <= '0;
                if (!w_inflight_next) begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= S_DRAIN;
                end
            end
        end
    end

    assign {w_head_mk, pix_data} = r_mem[r_rp];
    assign pix_valid  = (r_count != '0);
    assign pix_sof    = pix_valid & w_head_mk[2];
    assign pix_eol    = pix_valid & w_head_mk[1];
    assign pix_eof    = pix_valid & w_head_mk[0];
    assign vram_addr  = r_addr;
    assign vram_rd_en = r_rd_en;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_vram_frame_reader.sv
// tb/tb_vram_frame_reader.sv - directed and randomized checks of vram_frame_reader against a frame model
module tb_vram_frame_reader;

    localparam int DW    = 8;
    localparam int AW    = 32;
    localparam int W     = 4;
    localparam int H     = 3;
    localparam int N     = 2;
    localparam int RL    = 2;
    localparam int DEPTH = RL + 2;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [0:0]    image_sel;
    logic          half_mode;
    logic          abort;
    logic [AW-1:0] vram_addr;
    logic          vram_rd_en;
    logic [DW-1:0] vram_rdata;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_sof;
    logic          pix_eol;
    logic          pix_eof;
    logic          busy;
    logic          done;

    int n_assert = 0;
    int n_fail   = 0;

    vram_frame_reader #(
        .DATA_W(DW), .ADDR_W(AW), .IMG_W(W), .IMG_H(H), .N_IMG(N), .RD_LAT(RL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .image_sel(image_sel),
        .half_mode(half_mode), .abort(abort), .vram_addr(vram_addr),
        .vram_rd_en(vram_rd_en), .vram_rdata(vram_rdata), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof),
        .pix_eol(pix_eol), .pix_eof(pix_eof), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM: data = addr[7:0], valid exactly RL cycles after the read strobe.
    logic [AW-1:0] m_addr [RL];
    logic          m_v    [RL];
    always @(posedge clk) begin
        m_v[0]    <= vram_rd_en;
        m_addr[0] <= vram_addr;
        for (int k = 1; k < RL; k++) begin
            m_v[k]    <= m_v[k-1];
            m_addr[k] <= m_addr[k-1];
        end
    end
    assign vram_rdata = m_v[RL-1] ? m_addr[RL-1][7:0] : 8'hEE;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame: launch, watch every cycle, compare against the expected pixel list.
    task automatic run_frame(input int sel, input bit half, input bit rdy_rand,
                             input int abort_at, input bit hold_start,
                             input bit exact, input string nm);
        logic [DW+2:0] exp_q[$];
        logic [DW+2:0] out;
        logic [DW+2:0] prev_out;
        int  s, selc, addr;
        int  nxfer = 0, issued = 0, done_cnt = 0, done_cyc = -1;
        int  abort_cyc = -1, first_rd = -1, post_ab = 0;
        bit  prev_stall = 1'b0;
        bit  rdy;

        s    = half ? 2 : 1;
        selc = (sel > N - 1) ? N - 1 : sel;
        for (int y = 0; y < H; y += s) begin
            for (int x = 0; x < W; x += s) begin
                addr = selc * W * H + y * W + x;
                exp_q.push_back({(exp_q.size() == 0), (x + s >= W), 1'b0, addr[7:0]});
            end
        end
        exp_q[exp_q.size() - 1][DW] = 1'b1;

        @(negedge clk);
        image_sel = sel[0:0];
        half_mode = half;
        abort     = 1'b0;
        pix_ready = 1'b1;
        start     = 1'b1;
        prev_out  = '0;

        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            if (hold_start && c == 6) start = 1'b0;
            if (hold_start && c == 7) start = 1'b1;
            abort = 1'b0;
            out = {pix_sof, pix_eol, pix_eof, pix_data};

            if (vram_rd_en) begin
                issued++;
                if (first_rd < 0) first_rd = c;
            end
            chk({nm, " credit"}, 64'((issued - nxfer) <= DEPTH), 64'd1);
            if (c == 1) chk({nm, " busy c1"}, busy, 1'b1);
            if (prev_stall && abort_cyc < 0) begin
                chk({nm, " stall valid"}, pix_valid, 1'b1);
                chk({nm, " stall hold"}, out, prev_out);
            end
            if (abort_cyc >= 0 && c == abort_cyc + 1) chk({nm, " abort valid"}, pix_valid, 1'b0);
            if (done_cyc >= 0 && c > done_cyc) chk({nm, " busy after"}, busy, 1'b0);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                chk({nm, " busy at done"}, busy, 1'b0);
            end

            rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_ready = rdy;
            if (pix_valid && rdy) begin
                if (abort_cyc >= 0) begin
                    post_ab++;
                end else begin
                    if (nxfer < exp_q.size()) chk({nm, " pixel"}, out, exp_q[nxfer]);
                    else chk({nm, " extra pixel"}, out, '0);
                    if (exact) chk({nm, " xfer cycle"}, c, 4 + nxfer);
                    nxfer++;
                    if (nxfer == abort_at) begin
                        abort     = 1'b1;
                        abort_cyc = c;
                    end
                end
            end
            prev_stall = pix_valid && !rdy;
            prev_out   = out;
            if (done_cyc >= 0 && c >= done_cyc + 6) break;
        end
        abort     = 1'b0;
        pix_ready = 1'b1;

        chk({nm, " done seen"}, 64'(done_cyc >= 0), 64'd1);
        chk({nm, " done count"}, done_cnt, 1);
        chk({nm, " post-abort xfers"}, post_ab, 0);
        if (abort_at < 0) begin
            chk({nm, " count"}, nxfer, exp_q.size());
        end else begin
            chk({nm, " abort done lat"}, 64'((done_cyc > abort_cyc) && (done_cyc - abort_cyc <= RL + 1)), 64'd1);
        end
        if (exact) begin
            chk({nm, " first rd"}, first_rd, 1);
            chk({nm, " done cycle"}, done_cyc, exp_q.size() + RL + 2);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        image_sel = 1'b0;
        half_mode = 1'b0;
        abort     = 1'b0;
        pix_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset addr", vram_addr, '0);
        chk("reset data", pix_data, '0);
        chk("reset flags", {vram_rd_en, pix_valid, pix_sof, pix_eol, pix_eof, busy, done}, '0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle flags", {vram_rd_en, pix_valid, busy, done}, '0);

        run_frame(1, 1'b0, 1'b0, -1, 1'b0, 1'b1, "normal");
        run_frame(0, 1'b1, 1'b0, -1, 1'b0, 1'b1, "half");
        run_frame(0, 1'b0, 1'b1, -1, 1'b0, 1'b0, "random_ready");
        run_frame(1, 1'b1, 1'b1, -1, 1'b0, 1'b0, "random_half");
        run_frame(0, 1'b0, 1'b0, 5, 1'b0, 1'b0, "abort");
        run_frame(0, 1'b0, 1'b0, -1, 1'b0, 1'b1, "after_abort");
        run_frame(1, 1'b0, 1'b0, -1, 1'b1, 1'b0, "held_start");
        start = 1'b0;

        // Reset in the middle of a frame.
        @(negedge clk);
        image_sel = 1'b0;
        half_mode = 1'b0;
        start     = 1'b1;
        repeat (7) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 reset_n = 1'b0;
        #1;
        chk("midreset addr", vram_addr, '0);
        chk("midreset data", pix_data, '0);
        chk("midreset flags", {vram_rd_en, pix_valid, pix_sof, pix_eol, pix_eof, busy, done}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post reset quiet", {vram_rd_en, pix_valid, busy, done}, '0);
        end
        run_frame(1, 1'b0, 1'b0, -1, 1'b0, 1'b1, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
